// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register file / write-pending scoreboard.
// Holds datapath sizes, counter width and the request structs used between
// the top and its per-register counters.
package reg_file_scoreboard_pkg;
  localparam int DATA_W    = 32;
  localparam int NREG      = 16;
  localparam int REG_IDX_W = 4;
  localparam int CNT_W     = 2;

  // R15 doubles as the PC elsewhere in the core; this file treats it as
  // ordinary storage.
  localparam logic [REG_IDX_W-1:0] PC_IDX  = 4'd15;
  localparam logic [CNT_W-1:0]     CNT_MAX = '1;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_req_t;

  typedef struct packed {
    logic                 en;
    logic [REG_IDX_W-1:0] dest;
  } issue_req_t;
endpackage

// File: rtl/reg_file_scoreboard_sb_counter.sv
// sb_counter: one saturating pending-write counter for a single register.
// Ports:
//   clk, rst     clock, async active-low reset
//   inc          a new claim on this register this cycle
//   dec          a writeback retires a claim on this register this cycle
//   cnt          number of in-flight writers
//   err          pulses when an increment hits max or a decrement hits zero
module sb_counter
  import reg_file_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  logic up, dn;

  // Simultaneous claim and retire cancel out.
  assign up  = inc & ~dec;
  assign dn  = dec & ~inc;
  assign err = (up && cnt == CNT_MAX) || (dn && cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (up && cnt != CNT_MAX) cnt <= cnt + 1'b1;
    else if (dn && cnt != '0)      cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: architectural register file plus write-pending
// scoreboard beside the ID stage.
// Ports:
//   clk, rst               clock, async active-low reset
//   src1, src2, use_src2   read indices; use_src2 enables src2 hazard check
//   issue_en, issue_dest   destination claim from ID
//   WB_Enable, RD, WB_data writeback (writes data and retires one claim)
//   reg1, reg2             operands, with same-cycle writeback bypass
//   hazard                 a source is still owned by an in-flight writer
//   sb_err                 sticky counter overflow/underflow flag
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 use_src2,
  input  logic                 issue_en,
  input  logic [REG_IDX_W-1:0] issue_dest,
  input  logic                 WB_Enable,
  input  logic [REG_IDX_W-1:0] RD,
  input  logic [DATA_W-1:0]    WB_data,
  output logic [DATA_W-1:0]    reg1,
  output logic [DATA_W-1:0]    reg2,
  output logic                 hazard,
  output logic                 sb_err
);
  wb_req_t    wb;
  issue_req_t iss;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:0]             inc_vec, dec_vec, err_vec, busy;

  assign wb  = '{en: WB_Enable, rd: RD, data: WB_data};
  assign iss = '{en: issue_en, dest: issue_dest};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       regs <= '0;
    else if (wb.en) regs[wb.rd] <= wb.data;
  end

  // Bypass: a register being written this cycle is read as the new value.
  assign reg1 = (wb.en && wb.rd == src1) ? wb.data : regs[src1];
  assign reg2 = (wb.en && wb.rd == src2) ? wb.data : regs[src2];

  for (genvar i = 0; i < NREG; i++) begin : g_sb
    localparam logic [REG_IDX_W-1:0] IDX = REG_IDX_W'(i);

    assign inc_vec[i] = iss.en && iss.dest == IDX;
    assign dec_vec[i] = wb.en  && wb.rd    == IDX;

    sb_counter u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc_vec[i]),
      .dec (dec_vec[i]),
      .cnt (cnt[i]),
      .err (err_vec[i])
    );

    // Still owned after this cycle's retire; the retiring write itself is
    // covered by the bypass. A stray writeback to an idle register does not
    // make it look busy. Same-cycle issue is deliberately ignored.
    assign busy[i] = cnt[i] > {{(CNT_W-1){1'b0}}, dec_vec[i]};
  end

  assign hazard = busy[src1] || (use_src2 && busy[src2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          sb_err <= 1'b0;
    else if (|err_vec) sb_err <= 1'b1;
  end
endmodule
